// File: rtl/engine_layer_sched.sv
// engine_layer_sched: queues layer descriptors, gates one layer of weight packets into the engine
// and counts the engine's output packets to signal per-layer completion.
module engine_layer_sched #(
   parameter int CFG_DEPTH  = 4,
   parameter int CNT_BITS   = 16,
   parameter int LAYER_BITS = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CNT_BITS-1:0]   cfg_w_packets,
   input  logic [CNT_BITS-1:0]   cfg_o_packets,
   input  logic                  s_w_valid,
   output logic                  s_w_ready,
   input  logic                  s_w_last,
   output logic                  m_w_valid,
   input  logic                  m_w_ready,
   input  logic                  mon_valid,
   input  logic                  mon_ready,
   input  logic                  mon_last,
   output logic                  busy,
   output logic                  done,
   output logic [LAYER_BITS-1:0] layer_idx,
   output logic                  err
);
   localparam int AW = $clog2(CFG_DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, nxt;
   logic [CNT_BITS-1:0] w_mem [CFG_DEPTH];
   logic [CNT_BITS-1:0] o_mem [CFG_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic [CNT_BITS-1:0] w_cnt, o_cnt, w_tgt, o_tgt;
   logic                w_done, o_done, push, pop, gate, w_hs, mon_hs, o_hs, enter_run;

   assign cfg_ready = count != (AW+1)'(CFG_DEPTH);
   assign push      = cfg_valid & cfg_ready;
   assign pop       = state == DONE;
   assign w_tgt     = w_mem[rd_ptr];
   assign o_tgt     = o_mem[rd_ptr];
   assign gate      = (state == RUN) & !w_done;
   assign m_w_valid = s_w_valid & gate;
   assign s_w_ready = m_w_ready & gate;
   assign w_hs      = s_w_valid & s_w_ready & s_w_last;
   assign mon_hs    = mon_valid & mon_ready & mon_last;
   assign o_hs      = mon_hs & ((state == RUN) | (state == DRAIN)) & !o_done;
   assign enter_run = (state != RUN) & (nxt == RUN);
   assign busy      = state != IDLE;
   assign done      = state == DONE;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (count != '0) ? RUN : IDLE;
         RUN:     nxt = w_done ? (o_done ? DONE : DRAIN) : RUN;
         DRAIN:   nxt = o_done ? DONE : DRAIN;
         default: nxt = (count > (AW+1)'(1)) ? RUN : IDLE;
      endcase
   end

   // Targets are stored already normalised so a zero count behaves as one packet.
   always_ff @(posedge aclk) begin
      if (push) begin
         w_mem[wr_ptr] <= (cfg_w_packets == '0) ? CNT_BITS'(1) : cfg_w_packets;
         o_mem[wr_ptr] <= (cfg_o_packets == '0) ? CNT_BITS'(1) : cfg_o_packets;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         w_cnt     <= '0;
         o_cnt     <= '0;
         w_done    <= 1'b0;
         o_done    <= 1'b0;
         layer_idx <= '0;
         err       <= 1'b0;
      end else begin
         state <= nxt;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (pop) layer_idx <= layer_idx + LAYER_BITS'(1);
         if (mon_hs & !o_hs) err <= 1'b1;
         if (enter_run) begin
            w_cnt  <= '0;
            o_cnt  <= '0;
            w_done <= 1'b0;
            o_done <= 1'b0;
         end else begin
            if (w_hs) begin
               w_cnt <= w_cnt + CNT_BITS'(1);
               if (w_cnt == w_tgt - CNT_BITS'(1)) w_done <= 1'b1;
            end
            if (o_hs) begin
               o_cnt <= o_cnt + CNT_BITS'(1);
               if (o_cnt == o_tgt - CNT_BITS'(1)) o_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_engine_layer_sched.sv
// tb_engine_layer_sched: table-driven layers, directed corner sequences and a randomized run
// checked against a transaction-level descriptor queue model.
module tb_engine_layer_sched;
   logic        clk = 0;
   logic        aresetn = 0;
   logic        cfg_valid, cfg_ready, s_w_valid, s_w_ready, s_w_last, m_w_valid, m_w_ready;
   logic        mon_valid, mon_ready, mon_last, busy, done, err;
   logic [15:0] cfg_w_packets, cfg_o_packets;
   logic [7:0]  layer_idx;
   int          checks = 0, errors = 0;

   typedef struct {int w; int o; int ew; int eo;} vec_t;
   typedef struct {int w; int o;} desc_t;

   engine_layer_sched dut (
      .aclk(clk), .aresetn(aresetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_w_packets(cfg_w_packets), .cfg_o_packets(cfg_o_packets),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_last(s_w_last),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
      .busy(busy), .done(done), .layer_idx(layer_idx), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic zero_inputs();
      cfg_valid = 0; cfg_w_packets = 0; cfg_o_packets = 0;
      s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
      mon_valid = 0; mon_ready = 0; mon_last = 0;
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
      zero_inputs();
   endtask

   task automatic do_reset();
      aresetn = 0;
      zero_inputs();
      repeat (2) @(posedge clk);
      #1 aresetn = 1;
   endtask

   task automatic push(input int w, input int o);
      bit ok = 0;
      drive();
      cfg_valid = 1; cfg_w_packets = 16'(w); cfg_o_packets = 16'(o);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = cfg_ready;
         if (!ok) begin
            @(posedge clk);
            #1;
         end
      end
      chk("push_accept", 32'(ok), 1);
   endtask

   // Streams weights (beats per packet) and n_out output packets until done or budget expires.
   task automatic run_layer(input int beats, input int n_out, input bit w_after_out,
                            output int w_seen, output int o_seen, output bit got_done);
      int beat = 0;
      w_seen = 0; o_seen = 0; got_done = 0;
      for (int i = 0; i < 100 && !got_done; i++) begin
         drive();
         s_w_valid = !w_after_out || o_seen >= n_out;
         m_w_ready = 1;
         s_w_last  = (beat == beats - 1);
         mon_valid = busy && !done && o_seen < n_out;
         mon_ready = mon_valid;
         mon_last  = mon_valid;
         @(negedge clk);
         if (s_w_valid && s_w_ready) begin
            if (s_w_last) begin
               w_seen++;
               beat = 0;
            end else beat++;
         end
         if (mon_valid && mon_ready && mon_last) o_seen++;
         got_done = done;
      end
   endtask

   initial begin
      vec_t tbl[5];
      desc_t q[$];
      int ws, os, layers, w_seen, o_seen, dones, done_cyc, acc_cyc;
      bit gd, accepted, o_one;

      tbl = '{'{0, 0, 1, 1}, '{2, 3, 2, 3}, '{1, 1, 1, 1}, '{3, 1, 3, 1}, '{1, 4, 1, 4}};

      do_reset();
      s_w_valid = 1; m_w_ready = 1;
      @(negedge clk);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      chk("rst_s_w_ready", 32'(s_w_ready), 0);
      chk("rst_m_w_valid", 32'(m_w_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_layer_idx", 32'(layer_idx), 0);
      chk("rst_err", 32'(err), 0);

      foreach (tbl[i]) begin
         push(tbl[i].w, tbl[i].o);
         drive(); s_w_valid = 1; m_w_ready = 1;
         @(negedge clk);
         chk("tbl_gate_t1", 32'(m_w_valid), 0);
         drive(); s_w_valid = 1; m_w_ready = 0;
         @(negedge clk);
         chk("tbl_gate_t2", 32'(m_w_valid), 1);
         chk("tbl_ready_t2", 32'(s_w_ready), 0);
         run_layer(2, tbl[i].eo, 0, ws, os, gd);
         chk("tbl_done", 32'(gd), 1);
         chk("tbl_w_packets", 32'(ws), 32'(tbl[i].ew));
         chk("tbl_o_packets", 32'(os), 32'(tbl[i].eo));
         drive();
         @(negedge clk);
         chk("tbl_layer_idx", 32'(layer_idx), 32'(i + 1));
         chk("tbl_busy_after", 32'(busy), 0);
         chk("tbl_done_pulse", 32'(done), 0);
         chk("tbl_err", 32'(err), 0);
      end

      // back-to-back layers: the gate reopens the cycle right after each done pulse
      do_reset();
      for (int i = 0; i < 3; i++) push(1, 1);
      for (int l = 0; l < 3; l++) begin
         run_layer(1, 1, 0, ws, os, gd);
         chk("b2b_done", 32'(gd), 1);
         chk("b2b_w_packets", 32'(ws), 1);
         drive(); s_w_valid = 1; m_w_ready = 0;
         @(negedge clk);
         chk("b2b_gate_reopen", 32'(m_w_valid), 32'(l < 2));
         chk("b2b_busy", 32'(busy), 32'(l < 2));
         chk("b2b_layer_idx", 32'(layer_idx), 32'(l + 1));
      end

      // full FIFO: fifth descriptor only accepted the cycle after the first pop
      do_reset();
      for (int i = 0; i < 4; i++) push(1, 1);
      drive();
      @(negedge clk);
      chk("full_cfg_ready", 32'(cfg_ready), 0);
      accepted = 0; dones = 0; done_cyc = -1; acc_cyc = -2; o_one = 0;
      for (int i = 0; i < 300 && dones < 5; i++) begin
         drive();
         cfg_valid = !accepted; cfg_w_packets = 1; cfg_o_packets = 1;
         s_w_valid = 1; m_w_ready = 1; s_w_last = 1;
         mon_valid = busy && !done && !o_one; mon_ready = mon_valid; mon_last = mon_valid;
         @(negedge clk);
         if (cfg_valid && cfg_ready) begin
            accepted = 1;
            acc_cyc = i;
         end
         if (mon_valid && mon_ready && mon_last) o_one = 1;
         if (done) begin
            if (dones == 0) done_cyc = i;
            dones++;
            o_one = 0;
         end
      end
      chk("full_accept_cycle", 32'(acc_cyc), 32'(done_cyc + 1));
      chk("full_dones", 32'(dones), 5);
      drive();
      @(negedge clk);
      chk("full_layer_idx", 32'(layer_idx), 5);
      chk("full_busy", 32'(busy), 0);

      // unexpected output packets
      do_reset();
      drive(); mon_valid = 1; mon_ready = 1; mon_last = 1;
      @(negedge clk);
      chk("err_before", 32'(err), 0);
      drive();
      @(negedge clk);
      chk("err_idle", 32'(err), 1);
      do_reset();
      push(2, 3);
      run_layer(1, 4, 1, ws, os, gd);
      chk("err_extra_done", 32'(gd), 1);
      chk("err_extra_w", 32'(ws), 2);
      chk("err_extra_o_sent", 32'(os), 4);
      chk("err_extra_flag", 32'(err), 1);
      drive();
      @(negedge clk);
      chk("err_extra_layer_idx", 32'(layer_idx), 1);

      // asynchronous reset with a weight packet half-sent
      push(2, 1);
      gd = 0;
      for (int i = 0; i < 10 && !gd; i++) begin
         drive(); s_w_valid = 1; m_w_ready = 1; s_w_last = 0;
         @(negedge clk);
         gd = s_w_ready;
      end
      chk("arst_gate_opened", 32'(gd), 1);
      drive(); s_w_valid = 1; m_w_ready = 1; s_w_last = 0;
      #2 aresetn = 0;
      #1;
      chk("arst_m_w_valid", 32'(m_w_valid), 0);
      chk("arst_s_w_ready", 32'(s_w_ready), 0);
      chk("arst_cfg_ready", 32'(cfg_ready), 1);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_layer_idx", 32'(layer_idx), 0);
      chk("arst_err", 32'(err), 0);
      @(posedge clk);
      #1 aresetn = 1;
      push(1, 1);
      run_layer(1, 1, 0, ws, os, gd);
      chk("arst_new_done", 32'(gd), 1);
      chk("arst_new_w", 32'(ws), 1);
      drive();
      @(negedge clk);
      chk("arst_new_layer_idx", 32'(layer_idx), 1);
      chk("arst_fifo_empty", 32'(busy), 0);

      // randomized traffic against a descriptor-queue model
      do_reset();
      layers = 0; w_seen = 0; o_seen = 0;
      for (int i = 0; i < 5000; i++) begin
         if (i >= 4000 && q.size() == 0) break;
         drive();
         cfg_valid     = (i < 4000) && ($urandom_range(0, 3) == 0);
         cfg_w_packets = 16'($urandom_range(0, 3));
         cfg_o_packets = 16'($urandom_range(0, 3));
         s_w_valid     = 1'($urandom_range(0, 1));
         s_w_last      = 1'($urandom_range(0, 1));
         m_w_ready     = $urandom_range(0, 3) != 0;
         mon_valid     = busy && !done && ($urandom_range(0, 1) == 1);
         mon_ready     = $urandom_range(0, 3) != 0;
         mon_last      = q.size() > 0 && o_seen < q[0].o && ($urandom_range(0, 1) == 1);
         @(negedge clk);
         chk("rnd_cfg_ready", 32'(cfg_ready), 32'(q.size() < 4));
         chk("rnd_layer_idx", 32'(layer_idx), 32'(layers % 256));
         chk("rnd_err", 32'(err), 0);
         if (q.size() == 0) chk("rnd_idle_busy", 32'(busy), 0);
         if (!s_w_valid) chk("rnd_m_w_valid", 32'(m_w_valid), 0);
         if (!m_w_ready) chk("rnd_s_w_ready", 32'(s_w_ready), 0);
         if (s_w_valid && s_w_ready && s_w_last) begin
            chk("rnd_w_in_layer", 32'(q.size() > 0 && w_seen < q[0].w), 1);
            w_seen++;
         end
         if (mon_valid && mon_ready && mon_last) o_seen++;
         if (done) begin
            chk("rnd_done_has_layer", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               chk("rnd_done_w", 32'(w_seen), 32'(q[0].w));
               chk("rnd_done_o", 32'(o_seen), 32'(q[0].o));
               void'(q.pop_front());
            end
            layers++; w_seen = 0; o_seen = 0;
         end
         if (cfg_valid && cfg_ready) q.push_back('{eff(int'(cfg_w_packets)), eff(int'(cfg_o_packets))});
      end
      chk("rnd_drained", 32'(q.size()), 0);
      chk("rnd_progress", 32'(layers > 50), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
